// File: rtl/common_dffram_2a1wb2r_arb.sv
// Port-A arbiter and init sweeper for the 2-address 1-write 2-read DFF RAM.
// Two requesters share port A round-robin; every entry is swept to INIT_VALUE after reset/flush.
module common_dffram_2a1wb2r_arb #(
    parameter int unsigned RAM_DATA_WIDTH = 1,
    parameter int unsigned RAM_ADDR_WIDTH = 1,
    parameter logic [RAM_DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    output logic                      init_done,

    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [RAM_ADDR_WIDTH-1:0] req0_addr,
    input  logic [RAM_DATA_WIDTH-1:0] req0_we,
    input  logic [RAM_DATA_WIDTH-1:0] req0_wdata,
    output logic                      rsp0_valid,
    output logic [RAM_DATA_WIDTH-1:0] rsp0_rdata,

    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [RAM_ADDR_WIDTH-1:0] req1_addr,
    input  logic [RAM_DATA_WIDTH-1:0] req1_we,
    input  logic [RAM_DATA_WIDTH-1:0] req1_wdata,
    output logic                      rsp1_valid,
    output logic [RAM_DATA_WIDTH-1:0] rsp1_rdata,

    output logic [RAM_ADDR_WIDTH-1:0] ram_addra,
    output logic                      ram_ena,
    output logic [RAM_DATA_WIDTH-1:0] ram_wea,
    output logic [RAM_DATA_WIDTH-1:0] ram_dina,
    input  logic [RAM_DATA_WIDTH-1:0] ram_douta
);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                    state_q, state_d;
    logic [RAM_ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                      prio_q, prio_d;
    logic                      rsp0_valid_q, rsp0_valid_d;
    logic                      rsp1_valid_q, rsp1_valid_d;
    logic [RAM_DATA_WIDTH-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [RAM_DATA_WIDTH-1:0] rsp1_rdata_q, rsp1_rdata_d;
    logic                      grant0, grant1;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == StRun) begin
            if (prio_q == 1'b0) begin
                grant0 = req0_valid;
                grant1 = !req0_valid && req1_valid;
            end else begin
                grant1 = req1_valid;
                grant0 = !req1_valid && req0_valid;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        prio_d       = prio_q;
        rsp0_valid_d = grant0;
        rsp1_valid_d = grant1;
        rsp0_rdata_d = grant0 ? ram_douta : rsp0_rdata_q;
        rsp1_rdata_d = grant1 ? ram_douta : rsp1_rdata_q;
        ram_ena      = 1'b0;
        ram_addra    = '0;
        ram_wea      = '0;
        ram_dina     = '0;

        if (state_q == StInit) begin
            ram_ena   = 1'b1;
            ram_addra = cnt_q;
            ram_wea   = '1;
            ram_dina  = INIT_VALUE;
            // Counter wraps to 0 on the last entry, ready for the next sweep.
            cnt_d     = cnt_q + RAM_ADDR_WIDTH'(1);
            if (cnt_q == '1) begin
                state_d = StRun;
            end
        end else begin
            if (grant0) begin
                ram_ena   = 1'b1;
                ram_addra = req0_addr;
                ram_wea   = req0_we;
                ram_dina  = req0_wdata;
                prio_d    = 1'b1;
            end else if (grant1) begin
                ram_ena   = 1'b1;
                ram_addra = req1_addr;
                ram_wea   = req1_we;
                ram_dina  = req1_wdata;
                prio_d    = 1'b0;
            end
            if (flush) begin
                state_d = StInit;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StInit;
            cnt_q        <= '0;
            prio_q       <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prio_q       <= prio_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end

    assign init_done  = (state_q == StRun);
    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_common_dffram_2a1wb2r_arb.sv
// Bench for common_dffram_2a1wb2r_arb: table vectors, directed corner cases and random traffic
// checked against a shadow-memory / round-robin reference model.
module tb_common_dffram_2a1wb2r_arb;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 2;
    localparam int          DEPTH = 4;
    localparam logic [7:0]  INIT  = 8'hA5;

    logic          clk = 1'b0;
    logic          reset, flush, init_done;
    logic          req0_valid, req0_ready, rsp0_valid;
    logic          req1_valid, req1_ready, rsp1_valid;
    logic [AW-1:0] req0_addr, req1_addr, ram_addra, ram_addrb;
    logic [DW-1:0] req0_we, req0_wdata, rsp0_rdata, req1_we, req1_wdata, rsp1_rdata;
    logic          ram_ena;
    logic [DW-1:0] ram_wea, ram_dina, ram_douta, ram_doutb;

    always #5 clk = ~clk;

    common_dffram_2a1wb2r_arb #(
        .RAM_DATA_WIDTH(DW),
        .RAM_ADDR_WIDTH(AW),
        .INIT_VALUE    (INIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .init_done (init_done),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_addr (req0_addr),
        .req0_we   (req0_we),
        .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid),
        .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_addr (req1_addr),
        .req1_we   (req1_we),
        .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid),
        .rsp1_rdata(rsp1_rdata),
        .ram_addra (ram_addra),
        .ram_ena   (ram_ena),
        .ram_wea   (ram_wea),
        .ram_dina  (ram_dina),
        .ram_douta (ram_douta)
    );

    // RAM stand-in: bit-enable write on port A, combinational read-first reads on A and B.
    logic [DW-1:0] ram [DEPTH];
    always_ff @(posedge clk) begin
        if (ram_ena) ram[ram_addra] <= (ram[ram_addra] & ~ram_wea) | (ram_dina & ram_wea);
    end
    assign ram_douta = ram[ram_addra];
    assign ram_doutb = ram[ram_addrb];

    typedef struct {
        logic          v0, v1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] we0, we1, d0, d1;
        logic          fl;
        logic          er0, er1;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DW-1:0] mem [DEPTH];
    int            sweep_left;
    int            last_grant;
    logic          exp_v0, exp_v1;
    logic [DW-1:0] exp_d0, exp_d1;
    logic          swept;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v0, input logic v1, input logic [AW-1:0] a0,
                                input logic [AW-1:0] a1, input logic [DW-1:0] we0,
                                input logic [DW-1:0] d0, input logic fl,
                                input logic er0, input logic er1);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.a0 = a0; v.a1 = a1;
        v.we0 = we0; v.we1 = 8'h00; v.d0 = d0; v.d1 = 8'h00;
        v.fl = fl; v.er0 = er0; v.er1 = er1;
        return v;
    endfunction

    // One clock cycle: drive just after the rising edge, check at the falling edge,
    // then advance the model across the next rising edge.
    task automatic cycle(input vec_t v, output logic r0, output logic r1, output logic done);
        int            g;
        logic          ee;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew, ed, rd;
        req0_valid = v.v0; req0_addr = v.a0; req0_we = v.we0; req0_wdata = v.d0;
        req1_valid = v.v1; req1_addr = v.a1; req1_we = v.we1; req1_wdata = v.d1;
        flush      = v.fl;
        ram_addrb  = AW'($urandom_range(0, DEPTH - 1));
        @(negedge clk);
        r0   = req0_ready;
        r1   = req1_ready;
        done = init_done;
        if (sweep_left > 0) begin
            g = -1; ee = 1'b1; ea = AW'(DEPTH - sweep_left); ew = 8'hFF; ed = INIT;
        end else begin
            if (v.v0 && v.v1) g = 1 - last_grant;
            else if (v.v0)    g = 0;
            else if (v.v1)    g = 1;
            else              g = -1;
            ee = (g >= 0);
            ea = (g == 0) ? v.a0  : (g == 1) ? v.a1  : '0;
            ew = (g == 0) ? v.we0 : (g == 1) ? v.we1 : '0;
            ed = (g == 0) ? v.d0  : (g == 1) ? v.d1  : '0;
        end
        chk("req0_ready", 32'(req0_ready), 32'(g == 0));
        chk("req1_ready", 32'(req1_ready), 32'(g == 1));
        chk("ram_ena", 32'(ram_ena), 32'(ee));
        chk("ram_addra", 32'(ram_addra), 32'(ea));
        chk("ram_wea", 32'(ram_wea), 32'(ew));
        chk("ram_dina", 32'(ram_dina), 32'(ed));
        chk("init_done", 32'(init_done), 32'(sweep_left == 0));
        chk("rsp0_valid", 32'(rsp0_valid), 32'(exp_v0));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(exp_v1));
        chk("rsp0_rdata", 32'(rsp0_rdata), 32'(exp_d0));
        chk("rsp1_rdata", 32'(rsp1_rdata), 32'(exp_d1));
        if (swept) chk("doutb", 32'(ram_doutb), 32'(mem[ram_addrb]));
        exp_v0 = (g == 0);
        exp_v1 = (g == 1);
        if (sweep_left > 0) begin
            mem[ea] = INIT;
            sweep_left--;
            if (sweep_left == 0) swept = 1'b1;
        end else begin
            if (g >= 0) begin
                rd = mem[ea];
                if (g == 0) exp_d0 = rd;
                else        exp_d1 = rd;
                mem[ea]    = (mem[ea] & ~ew) | (ed & ew);
                last_grant = g;
            end
            if (v.fl) sweep_left = DEPTH;
        end
        @(posedge clk);
        #1;
    endtask

    // Reset asserted asynchronously for n cycles; outputs must clear at once.
    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst_init_done", 32'(init_done), 32'd0);
            chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
            chk("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
            chk("rst_rdata", 32'({rsp0_rdata, rsp1_rdata}), 32'd0);
            chk("rst_ram_ena", 32'(ram_ena), 32'd1);
            chk("rst_ram_addra", 32'(ram_addra), 32'd0);
            chk("rst_ram_wea", 32'(ram_wea), 32'hFF);
            chk("rst_ram_dina", 32'(ram_dina), 32'(INIT));
            mem[0] = INIT;
            @(posedge clk);
            #1;
        end
        reset      = 1'b0;
        sweep_left = DEPTH;
        last_grant = 1;
        exp_v0 = 1'b0; exp_v1 = 1'b0;
        exp_d0 = '0;   exp_d1 = '0;
    endtask

    vec_t idle;
    vec_t tbl[$];
    vec_t rv;
    logic r0, r1, dn;
    int   n;

    initial begin
        reset = 1'b1; flush = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_we = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_we = '0; req1_wdata = '0;
        ram_addrb = '0;
        swept = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = INIT;
        idle = mk(1'b0, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;

        // Reset and initial sweep: init_done must appear after exactly DEPTH cycles.
        do_reset(2);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(idle, r0, r1, dn);
            if (dn) break;
            n++;
        end
        chk("sweep_len", 32'(n), 32'(DEPTH));

        // Read every entry through requester 1 (keeps prio at 0).
        for (int i = 0; i < DEPTH; i++) begin
            rv = idle;
            rv.v1 = 1'b1; rv.a1 = AW'(i);
            cycle(rv, r0, r1, dn);
            cycle(idle, r0, r1, dn);
            chk("sweep_value", 32'(rsp1_rdata), 32'(INIT));
        end

        // Single requester 1 for three cycles, then six cycles of full contention.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b0, 1'b1, 2'd0, 2'(i), 8'h00, 8'h00,
                                                     1'b0, 1'b0, 1'b1));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(1'b1, 1'b1, 2'(i), 2'(3 - (i % 4)), 8'h00,
                                                     8'h00, 1'b0, (i % 2) == 0, (i % 2) == 1));
        tbl.push_back(idle);
        foreach (tbl[k]) begin
            cycle(tbl[k], r0, r1, dn);
            chk($sformatf("tbl%0d_ready0", k), 32'(r0), 32'(tbl[k].er0));
            chk($sformatf("tbl%0d_ready1", k), 32'(r1), 32'(tbl[k].er1));
        end

        // Read-first partial write, then read back the merged value.
        cycle(mk(1'b1, 1'b0, 2'd2, 2'd0, 8'h0F, 8'h3C, 1'b0, 1'b0, 1'b0), r0, r1, dn);
        chk("rmw_old", 32'(rsp0_rdata), 32'hA5);
        cycle(mk(1'b1, 1'b0, 2'd2, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0), r0, r1, dn);
        chk("rmw_new", 32'(rsp0_rdata), 32'hAC);

        // Flush together with a granted write; requests during the sweep are held off.
        cycle(mk(1'b1, 1'b0, 2'd1, 2'd0, 8'hFF, 8'h11, 1'b1, 1'b0, 1'b0), r0, r1, dn);
        chk("flush_rsp_valid", 32'(rsp0_valid), 32'd1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(mk(1'b0, 1'b1, 2'd0, 2'd1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0), r0, r1, dn);
            if (dn) break;
            n++;
        end
        chk("flush_sweep_len", 32'(n), 32'(DEPTH));
        cycle(mk(1'b1, 1'b0, 2'd1, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0), r0, r1, dn);
        cycle(idle, r0, r1, dn);
        chk("flush_value", 32'(rsp0_rdata), 32'(INIT));

        // Reset in the middle of a sweep restarts it from entry 0.
        cycle(mk(1'b0, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0), r0, r1, dn);
        cycle(idle, r0, r1, dn);
        cycle(idle, r0, r1, dn);
        do_reset(1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(idle, r0, r1, dn);
            if (dn) break;
            n++;
        end
        chk("midreset_sweep_len", 32'(n), 32'(DEPTH));

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            rv.v0  = 1'($urandom_range(0, 1));
            rv.v1  = 1'($urandom_range(0, 1));
            rv.a0  = AW'($urandom_range(0, DEPTH - 1));
            rv.a1  = AW'($urandom_range(0, DEPTH - 1));
            rv.we0 = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
            rv.we1 = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
            rv.d0  = 8'($urandom);
            rv.d1  = 8'($urandom);
            rv.fl  = ($urandom_range(0, 39) == 0);
            rv.er0 = 1'b0;
            rv.er1 = 1'b0;
            cycle(rv, r0, r1, dn);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/common_dffram_2a1wb2r_arb.md
# common_dffram_2a1wb2r_arb

Port-A arbiter and initializer for the 2-address, 1-write, 2-read DFF RAM with bit-enable write. Two requesters share the RAM read/write port A through valid/ready handshakes with round-robin arbitration. After reset, or on a flush request, the block sweeps every RAM entry to a programmable init value. Port B, the read-only port, is not touched by this block and stays wired directly to its consumer.

## Interface
- RAM_DATA_WIDTH, 1, data width; must match the RAM instance.
- RAM_ADDR_WIDTH, 1, address width; depth = 2^RAM_ADDR_WIDTH.
- INIT_VALUE, all zeros, RAM_DATA_WIDTH-bit value written to every entry during a sweep.

- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  request to re-run the init sweep; sampled only in RUN.
- init_done  out  1  high in RUN; low in INIT.
- req0_valid / req1_valid  in  1  requester n has a valid access.
- req0_ready / req1_ready  out  1  access of requester n is accepted this cycle.
- req0_addr / req1_addr  in  RAM_ADDR_WIDTH  access address.
- req0_we / req1_we  in  RAM_DATA_WIDTH  per-bit write mask; all zero = pure read.
- req0_wdata / req1_wdata  in  RAM_DATA_WIDTH  write data.
- rsp0_valid / rsp1_valid  out  1  one-cycle pulse: read data for requester n is valid.
- rsp0_rdata / rsp1_rdata  out  RAM_DATA_WIDTH  registered read data; holds until the next response to that requester.
- ram_addra  out  RAM_ADDR_WIDTH  to RAM addra.
- ram_ena  out  1  to RAM ena.
- ram_wea  out  RAM_DATA_WIDTH  to RAM wea.
- ram_dina  out  RAM_DATA_WIDTH  to RAM dina.
- ram_douta  in  RAM_DATA_WIDTH  from RAM douta: combinational, read-first.

## Operation
- FSM states: INIT, RUN. Reset value is INIT.
- **INIT state**
  - Address counter `cnt` (RAM_ADDR_WIDTH bits) starts at 0.
  - Each cycle drives ram_ena=1, ram_wea=all ones, ram_addra=cnt, ram_dina=INIT_VALUE, then increments cnt.
  - When cnt == DEPTH-1, the write completes and the next state is RUN; cnt wraps to 0.
  - Both ready outputs are 0; flush is ignored.
- **RUN state, arbitration**
  - 1-bit priority pointer `prio`, reset value 0.
  - Grant goes to requester `prio` if its valid is high, otherwise to the other requester if its valid is high, otherwise to no one.
  - req_ready of the granted requester = 1 (combinational from the valids, state and prio); the other ready = 0.
  - On any grant, prio <= the index of the requester not granted. With no grant, prio holds.
- **RUN state, RAM drive**
  - ram_ena = 1 only on a grant cycle.
  - ram_addra / ram_wea / ram_dina = the granted requester's addr / we / wdata.
  - With no grant: ram_ena=0, ram_wea=0; addr and data are don't-care, driven 0.
- **Responses**
  - Every granted access (read or write) produces exactly one response.
  - ram_douta is captured into rsp<n>_rdata at the grant edge, and rsp<n>_valid=1 in the following cycle.
  - Because the RAM is read-first, a write returns the pre-write contents (read-modify-write semantics).
- **Flush**
  - flush=1 in RUN means state <= INIT and cnt <= 0.
  - A grant in the same cycle as flush is still performed and still responded to; flush takes effect from the next cycle.
- Reset mid-operation: state=INIT, cnt=0, prio=0; all rsp_valid, rsp_rdata and init_done are cleared immediately. Any in-flight response is dropped.

## Timing
- Reset values of outputs: init_done=0, req*_ready=0, rsp*_valid=0, rsp*_rdata=0, ram_ena=1 (INIT begins writing entry 0), ram_addra=0, ram_wea=all ones, ram_dina=INIT_VALUE.
- Sweep: exactly DEPTH cycles of INIT after reset deassertion or after the flush edge. init_done rises in cycle DEPTH, i.e. it is registered with state.
- Request latency: ready is in the same cycle as valid if granted; response arrives 1 cycle after acceptance.
- Throughput: one access per cycle in total. Under continuous contention the grants strictly alternate 0,1,0,1...
- A requester must hold valid, addr, we and wdata stable until ready; ready never depends on the requester's own addr or data.
- Back-to-back accesses to the same address: the second access observes the first write. That write is committed at the grant edge, and ram_douta in the next cycle reflects it.

## Test plan
- **Reset sweep:** with DATA=8, ADDR=2, INIT_VALUE=0xA5, release reset → ram_addra runs 0,1,2,3 with wea=0xFF over 4 cycles and init_done=1 in cycle 4. Reading each address afterwards returns 0xA5 and doutb agrees.
- **Contention:** hold req0_valid and req1_valid high for 6 cycles → grants go 0,1,0,1,0,1. Each rsp pulses exactly one cycle after its ready.
- **Read-first write:** with addr 2=0xA5, req0 writes wdata=0x3C with we=0x0F → rsp0_rdata=0xA5. A following read of addr 2 returns 0xAC.
- **Single requester:** req1 alone for 3 cycles with prio=0 → req1_ready=1 in every cycle and req0_ready=0.
- **Flush:** assert flush together with a granted req0 write of 0x11 to addr 1 → the response is delivered, init_done drops next cycle, a 4-cycle sweep follows, and addr 1 then reads INIT_VALUE. Requests during the sweep see ready=0.
- **Mid-sweep reset:** assert reset at sweep cycle 2 → cnt restarts at 0 and a full 4-cycle sweep completes before init_done=1.
